// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and default sizes for the systolic feature skewer
package systolic_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_ROWS  = 32;
    localparam int DEFAULT_LEN_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } skew_state_t;

    typedef logic [DEFAULT_WIDTH-1:0] feat_t;

endpackage

// File: rtl/systolic_feature_skewer_if.sv
// rtl/systolic_feature_skewer_if.sv - control, column stream and skewed output bundle
interface systolic_feature_skewer_if
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ROWS  = DEFAULT_ROWS,
    parameter int LEN_W = DEFAULT_LEN_W
);
    localparam int RW = $clog2(ROWS + 1);

    logic             start;
    logic [LEN_W-1:0] stream_len;
    logic [RW-1:0]    active_rows;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data [ROWS];
    logic             feat_valid;
    logic [WIDTH-1:0] feat_out [ROWS];
    logic             busy;
    logic             done;
    logic             proto_err;

    modport master (
        output start, stream_len, active_rows, in_valid, in_data,
        input  in_ready, feat_valid, feat_out, busy, done, proto_err
    );

    modport slave (
        input  start, stream_len, active_rows, in_valid, in_data,
        output in_ready, feat_valid, feat_out, busy, done, proto_err
    );

endinterface

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage enabled shift register with synchronous clear
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feature_skewer.sv
// rtl/systolic_feature_skewer.sv - skews unskewed feature columns diagonally for the systolic array
// Optional sticky protocol checker: SKEW_PROTOCOL_CHK_EN
module systolic_feature_skewer
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ROWS  = DEFAULT_ROWS,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input logic clk,
    input logic rst,
    systolic_feature_skewer_if.slave bus
);

    localparam int RW = $clog2(ROWS + 1);

    skew_state_t      state, state_n;
    logic             advance;
    logic             accept_start;
    logic             in_ready_c;
    logic             done_c;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] col_cnt;
    logic [RW-1:0]    rows_q;
    logic [RW-1:0]    drain_cnt;
    logic             feat_valid_q;
    logic [WIDTH-1:0] feat_q [ROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        in_ready_c   = 1'b0;
        advance      = 1'b0;
        accept_start = 1'b0;
        done_c       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_start = 1'b1;
                    if (bus.stream_len == '0 || bus.active_rows == '0) state_n = DONE;
                    else                                                 state_n = STREAM;
                end
            end
            STREAM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    advance = 1'b1;
                    if (col_cnt == len_q - LEN_W'(1))
                        state_n = (rows_q > RW'(1)) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                advance = 1'b1;
                if (drain_cnt == rows_q - RW'(2)) state_n = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters restart on every accepted start so a pass never inherits stale counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            rows_q       <= '0;
            col_cnt      <= '0;
            drain_cnt    <= '0;
            feat_valid_q <= 1'b0;
        end else begin
            feat_valid_q <= advance;
            if (accept_start) begin
                len_q     <= bus.stream_len;
                rows_q    <= bus.active_rows;
                col_cnt   <= '0;
                drain_cnt <= '0;
            end else begin
                if (state == STREAM && advance) col_cnt   <= col_cnt + LEN_W'(1);
                if (state == DRAIN)             drain_cnt <= drain_cnt + RW'(1);
            end
        end
    end

    // Row j gets j+1 stages so column k of row j surfaces on output beat k+j.
    for (genvar j = 0; j < ROWS; j++) begin : g_row
        logic [WIDTH-1:0] lane_in;
        assign lane_in = (state == STREAM && RW'(j) < rows_q) ? bus.in_data[j] : '0;

        skew_delay_line #(
            .DEPTH (j + 1),
            .WIDTH (WIDTH)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .clr (accept_start),
            .en  (advance),
            .d   (lane_in),
            .q   (feat_q[j])
        );
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.feat_valid = feat_valid_q;
    assign bus.feat_out   = feat_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_c;

`ifdef SKEW_PROTOCOL_CHK_EN
    logic proto_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            proto_q <= 1'b0;
        else if (accept_start)
            proto_q <= 1'b0;
        else if ((bus.start && state != IDLE) || (state == DRAIN && bus.in_valid))
            proto_q <= 1'b1;
    end

    assign bus.proto_err = proto_q;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: doc/systolic_feature_skewer.md
Name: systolic_feature_skewer

Overview:
Feeds the feature side of the systolic convolution array. It accepts one unskewed column per transfer, holding element k of every active row, and emits the diagonally skewed vector the array needs: row j is delayed j cycles. After the last column it drains with zero padding. A start/busy/done protocol sequences one convolution pass, replacing hand-built per-row skewing and random padding.

Parameters:
WIDTH, 16, bits per feature element
ROWS, 32, physical array rows / output lanes
LEN_W, 10, width of stream-length field (max pass length 2**LEN_W-1; 784 for 28x28)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
start  in  1  one-cycle pulse; begins a pass when idle
stream_len  in  LEN_W  columns per row this pass, sampled on accepted start
active_rows  in  $clog2(ROWS+1)  rows in use (1..ROWS), sampled on accepted start
in_valid  in  1  in_data holds a valid column
in_ready  out  1  block accepts a column this cycle
in_data  in  ROWS x WIDTH  unpacked array; lane j = element k of row j
feat_valid  out  1  feat_out updated by an advance this cycle
feat_out  out  ROWS x WIDTH  skewed feature vector to array rows
busy  out  1  pass in progress (state != IDLE)
done  out  1  one-cycle pulse with the final feat_valid of a pass
proto_err  out  1  sticky protocol error (optional feature)

Behaviour:
- Reset values: in_ready=0, feat_valid=0, feat_out=all 0, busy=0, done=0, proto_err=0; state=IDLE; all delay registers cleared. Reset mid-pass aborts it immediately, with no done pulse.
- Advance: (STREAM && in_valid && in_ready) || DRAIN. All delay lines shift only on advance. feat_valid is the advance, registered one cycle later. feat_out holds its value between advances.
- Row j uses a j+1-stage delay line. Lane input = in_data[j] in STREAM, 0 in DRAIN, and 0 for every j >= active_rows.
- Output contract: on the t-th feat_valid of a pass (t = 0 .. L+R-2), feat_out[j] = column (t-j) of row j when 0 <= t-j < L, else 0. Here L = stream_len and R = active_rows.
- FSM, IDLE: in_ready=0. An accepted start clears all delay lines and latches L and R.
  - L == 0 or R == 0: go straight to DONE with no feat_valid. done still pulses.
  - Otherwise: go to STREAM.
- FSM, STREAM: in_ready=1. A column counter increments per accepted column. On accepting column L-1: go to DRAIN if R > 1, else go to DONE. in_valid low stalls the pass, with no feat_valid.
- FSM, DRAIN: in_ready=0. Advances every cycle; the counter runs R-1 cycles, then goes to DONE.
- FSM, DONE: done=1 for one cycle, coinciding with the last feat_valid. Then go to IDLE.
- Total feat_valid count per pass is L+R-1, e.g. 808 for L=784, R=25.
- start while busy is ignored. in_valid outside STREAM is ignored; data is dropped.
- Counter equal to L-1 = 2**LEN_W-2 terminates correctly with no wrap. Counters are LEN_W bits.

Optional Feature:
SKEW_PROTOCOL_CHK_EN
- Defined: proto_err sets (sticky) on start while busy, or on in_valid while not in_ready during DRAIN. It clears on rst or on an accepted start.
- Undefined: proto_err is tied to 0 and no checking logic is built.

Decomposition:
- Package systolic_pkg holds:
  - skew_state_t enum {IDLE, STREAM, DRAIN, DONE}
  - feat_t typedef (logic [WIDTH-1:0])
  - default constants WIDTH = 16, ROWS = 32
- One sub-module, skew_delay_line: parameters DEPTH and WIDTH; ports clk, rst, clr, en, d, q. It is instantiated ROWS times with DEPTH = j+1 from a generate loop.

Test Plan:
1. ROWS=32, start with L=4, R=3; in_data[j] = 10*j+k, in_valid held 1 -> 6 feat_valid. Vectors: lane0 = 0,1,2,3,0,0; lane1 = 0,10,11,12,13,0; lane2 = 0,0,20,21,22,23; lanes 3..31 = 0. done pulses with the 6th.
2. L=784, R=25, image and check files from the convolution bench -> exactly 808 feat_valid. feat_out[24] first equals row24[0] at t=24 and last at t=807. The array output matches check1/check2.
3. L=5, R=2, in_valid deasserted for 3 cycles after column 2 -> no feat_valid during the stall, feat_out held, stream resumes intact, total 6 valids.
4. rst asserted at cycle 100 of an L=784 pass -> outputs zero asynchronously, busy=0, no done. A new start with L=2, R=1 yields lane0 = 2 values, done after the 2nd.
5. L=0, R=5 -> done one cycle after DONE entry, zero feat_valid. With L=3, R=1 -> 3 valids, no DRAIN.
6. With SKEW_PROTOCOL_CHK_EN defined: start during STREAM -> proto_err=1, sticky until the next accepted start. Without the macro the same stimulus gives proto_err=0.
